mealy_seq_detector: RTL and testbench
=====================================

# mealy_seq_detector

Parametrised Mealy sequence detector: watches a serial bit stream qualified by a valid strobe and asserts a same-cycle match pulse whenever the last PAT_W accepted bits equal a programmable pattern. It is the generalised successor to the team's fixed two-state detectors. It adds runtime pattern loading, selectable overlapping or non-overlapping matching, and a saturating match counter. It sits between a serial front end and control logic that needs per-bit match indication.

## Interface
- PAT_W, 4, pattern length in bits, ≥2
- PATTERN, 4'b1011, reset value of the pattern register; bit PAT_W-1 is the first bit of the sequence in time
- CNT_W, 8, match counter width, ≥1

- clk  input  1  clock, rising edge
- reset  input  1  asynchronous, active-high; clears all state immediately
- in_valid  input  1  in_bit is accepted on this cycle's rising edge
- in_bit  input  1  serial data bit
- overlap  input  1  1 = overlapping matches, 0 = non-overlapping; sampled on each accepted bit
- pat_load  input  1  load pat_in into the pattern register at this edge
- pat_in  input  PAT_W  new pattern, same bit ordering as PATTERN
- count_clr  input  1  synchronous clear of match_count
- out  output  1  Mealy match pulse, combinational
- match_count  output  CNT_W  number of matches since reset or clear, saturating
- count_sat  output  1  match_count equals all-ones

## Operation
- **State:** `k`, range 0..PAT_W-1. `k` is the length of the longest prefix of the pattern that equals the most recent `k` accepted bits since the last restart.
  - Implementation is free: a KMP-style table or a history register plus a combinational prefix compare.
- **Accepted bit:** in_valid=1 and pat_load=0. Candidate length is `k+1` over the accepted bit appended to the history.
- **Match:** `k`=PAT_W-1 and in_bit equals pattern bit 0.
  - out=1 combinationally in that cycle.
  - out is gated low whenever reset=1, in_valid=0 or pat_load=1.
- **Next `k` when there is no match:** the longest prefix of the pattern, of length ≤`k+1`, that equals the suffix of the history plus the accepted bit. The detector falls back and does not simply return to 0.
- **Next `k` on a match:**
  - overlap=1: length of the longest proper border of the pattern, i.e. a prefix that is also a suffix, of length <PAT_W.
  - overlap=0: `k`=0.
- **in_valid=0:** `k` and the history hold. out=0.
- **pat_load=1:**
  - Pattern register takes pat_in.
  - `k`=0 and the history is emptied.
  - in_bit is discarded this cycle, even if in_valid=1.
- **Counter:**
  - On a match cycle, match_count increments if it is below all-ones; otherwise it holds.
  - count_clr=1 forces 0 at the edge. count_clr wins over a simultaneous match, which is not counted.
- **count_sat:** combinational, equal to (match_count == all-ones).
- **Reset values:** `k`=0, history empty, pattern register=PATTERN, match_count=0, count_sat=0, out=0.
- **Reset mid-stream:**
  - Any partial match is lost.
  - The first accepted bit after reset deasserts starts a fresh search.
  - Any pattern loaded at runtime is discarded.

## Timing
- **Latency:** out is valid in the same cycle as the completing in_bit, after combinational settling. It is zero-latency, Mealy.
- **Update timing:** `k`, the history, the pattern register and match_count update on the rising clk edge.
  - match_count reflects a match in the cycle after the out pulse.
- **Reset:** assertion clears state without a clock edge. Deassertion must be synchronised externally; the block assumes a clean release relative to clk.
- **Back-to-back:** one match per accepted bit at most.
  - Minimum spacing between matches is PAT_W − border length with overlap=1, and PAT_W with overlap=0.
- **Mode changes:** a change of overlap affects only the next match's restart value. It does not affect the current `k`.

## Test plan
- **Basic match, fallback, counter and count_sat:** reset, PATTERN=4'b1011, overlap=1. Feed 1,0,1,1,0,1,1 with in_valid=1.
  - out=1 on bits 4 and 7, and 0 elsewhere.
  - match_count=2 one cycle after bit 7.
  - Feed 1,1,0,1,1 → out=1 only on bit 5, which checks fallback from "11" to `k`=1.
  - Set CNT_W=2 and produce 4 matches → match_count sticks at 3, count_sat=1.
- **Non-overlap mode:** same 7-bit stream with overlap=0 → out=1 only on bit 4, and match_count=1.
- **Valid gaps:** feed 1,0,1,1 with in_valid=0 cycles inserted between bits, in_bit toggling during the gaps.
  - out=1 exactly on the 4th accepted bit.
  - out=0 during every gap.
- **Runtime load:**
  - Pulse pat_load with pat_in=4'b0110 after 1,0,1 has been accepted. The next 1 must not match.
  - Then feed 0,1,1,0 → out=1 on its 4th bit.
  - Assert pat_load and in_valid together → in_bit is ignored and out=0.
- **Clear priority:**
  - count_clr=1 in the same cycle as a match → out=1, and match_count=0 next cycle.
- **Async reset mid-pattern:** after 1,0,1, assert reset between clock edges.
  - match_count=0 and out=0 immediately.
  - After release, feeding 1 does not match.
  - Feeding 1,0,1,1 matches on its 4th bit.

Source files
------------

// File: rtl/mealy_seq_detector.sv
// Parametrised Mealy sequence detector with runtime-loadable pattern,
// overlapping/non-overlapping restart and a saturating match counter.
module mealy_seq_detector #(
  parameter int               PAT_W   = 4,
  parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
  parameter int               CNT_W   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic             in_bit,
  input  logic             overlap,
  input  logic             pat_load,
  input  logic [PAT_W-1:0] pat_in,
  input  logic             count_clr,
  output logic             out,
  output logic [CNT_W-1:0] match_count,
  output logic             count_sat
);

  localparam int KW = $clog2(PAT_W);
  typedef logic [KW-1:0] k_t;

  localparam k_t               K_ZERO   = {KW{1'b0}};
  localparam k_t               K_LAST   = k_t'(PAT_W - 1);
  localparam logic [PAT_W-1:0] P_ONES   = {PAT_W{1'b1}};
  localparam logic [PAT_W-1:0] P_ZERO   = {PAT_W{1'b0}};
  localparam logic [PAT_W-2:0] H_ZERO   = {(PAT_W-1){1'b0}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONES = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  k_t               k_q, k_d;
  logic [PAT_W-2:0] hist_q, hist_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             accept_s;
  logic             match_s;
  logic [PAT_W-1:0] cand_s;
  k_t               fall_s;

  // Newest bit sits at cand_s[0]; only the last k+1 bits belong to the current search.
  assign cand_s   = {hist_q, in_bit};
  assign accept_s = in_valid & ~pat_load;
  assign match_s  = accept_s & (k_q == K_LAST) & (in_bit == pat_q[0]);

  assign out         = match_s & ~reset;
  assign match_count = cnt_q;
  assign count_sat   = (cnt_q == CNT_ONES);

  // Longest pattern prefix (len <= k+1, < PAT_W) equal to the candidate suffix;
  // on a full match this is the pattern's longest proper border.
  always_comb begin
    fall_s = K_ZERO;
    for (int len = 1; len < PAT_W; len++) begin
      if ((len <= int'(k_q) + 1) &&
          (((cand_s ^ (pat_q >> (PAT_W - len))) & (P_ONES >> (PAT_W - len))) == P_ZERO)) begin
        fall_s = k_t'(len);
      end else begin
        fall_s = fall_s;
      end
    end
  end

  // Next-state for search state, pattern register and match counter.
  always_comb begin
    k_d    = k_q;
    hist_d = hist_q;
    pat_d  = pat_q;
    cnt_d  = cnt_q;

    if (pat_load) begin
      pat_d  = pat_in;
      k_d    = K_ZERO;
      hist_d = H_ZERO;
    end else if (in_valid) begin
      hist_d = cand_s[PAT_W-2:0];
      if (match_s) begin
        k_d = overlap ? fall_s : K_ZERO;
      end else begin
        k_d = fall_s;
      end
    end else begin
      k_d = k_q;
    end

    if (count_clr) begin
      cnt_d = CNT_ZERO;
    end else if (match_s && (cnt_q != CNT_ONES)) begin
      cnt_d = cnt_q + CNT_ONE;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // State registers; reset also restores the power-on pattern.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      k_q    <= K_ZERO;
      hist_q <= H_ZERO;
      pat_q  <= PATTERN;
      cnt_q  <= CNT_ZERO;
    end else begin
      k_q    <= k_d;
      hist_q <= hist_d;
      pat_q  <= pat_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mealy_seq_detector.sv
// Directed table-driven bench for mealy_seq_detector: an 8-bit counter
// instance and a 2-bit counter instance share one stimulus stream.
module tb_mealy_seq_detector;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid, in_bit, overlap, pat_load, count_clr;
  logic [3:0] pat_in;
  logic       out, out2, count_sat, count_sat2;
  logic [7:0] match_count;
  logic [1:0] match_count2;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       v, b, ov, ld;
    logic [3:0] pin;
    logic       clr, eo;
    logic [7:0] ec;
    logic [1:0] ec2;
    logic       es2;
  } vec_t;

  vec_t tbl[$];

  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(8)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
    .count_clr(count_clr), .out(out), .match_count(match_count),
    .count_sat(count_sat)
  );

  mealy_seq_detector #(.PAT_W(4), .PATTERN(4'b1011), .CNT_W(2)) dut2 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_bit(in_bit),
    .overlap(overlap), .pat_load(pat_load), .pat_in(pat_in),
    .count_clr(count_clr), .out(out2), .match_count(match_count2),
    .count_sat(count_sat2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input int v, input int b, input int ov, input int ld,
                              input int pin, input int clr, input int eo,
                              input int ec, input int ec2, input int es2);
    vec_t t;
    t.v = v[0]; t.b = b[0]; t.ov = ov[0]; t.ld = ld[0];
    t.pin = pin[3:0]; t.clr = clr[0]; t.eo = eo[0];
    t.ec = ec[7:0]; t.ec2 = ec2[1:0]; t.es2 = es2[0];
    return t;
  endfunction

  task automatic add(input int v, input int b, input int ov, input int ld, input int pin,
                     input int clr, input int eo, input int ec, input int ec2, input int es2);
    tbl.push_back(mk(v, b, ov, ld, pin, clr, eo, ec, ec2, es2));
  endtask

  // Called just after a rising edge: drive, check out mid-cycle, check counters after the edge.
  task automatic step(input vec_t t, input string tag);
    in_valid  = t.v;
    in_bit    = t.b;
    overlap   = t.ov;
    pat_load  = t.ld;
    pat_in    = t.pin;
    count_clr = t.clr;
    @(negedge clk);
    chk({tag, " out"},  {7'b0, out},  {7'b0, t.eo});
    chk({tag, " out2"}, {7'b0, out2}, {7'b0, t.eo});
    @(posedge clk);
    #1;
    chk({tag, " cnt"},  match_count, t.ec);
    chk({tag, " cnt2"}, {6'b0, match_count2}, {6'b0, t.ec2});
    chk({tag, " sat2"}, {7'b0, count_sat2}, {7'b0, t.es2});
  endtask

  initial begin
    //  v  b ov ld  pin    clr eo cnt c2 s2
    // overlapping: 1011011, then fallback 11011, then 011 saturates the 2-bit counter
    add(1, 1, 1, 0, 0,       0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0,       0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0,       0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0,       0, 1, 1, 1, 0);
    add(1, 0, 1, 0, 0,       0, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0,       0, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0,       0, 1, 2, 2, 0);
    add(1, 1, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 1, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 0, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 1, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 1, 1, 0, 0,       0, 1, 3, 3, 1);
    add(1, 0, 1, 0, 0,       0, 0, 3, 3, 1);
    add(1, 1, 1, 0, 0,       0, 0, 3, 3, 1);
    add(1, 1, 1, 0, 0,       0, 1, 4, 3, 1);
    // restart search and clear counters
    add(0, 0, 1, 1, 4'b1011, 1, 0, 0, 0, 0);
    // non-overlapping: 1011011
    add(1, 1, 0, 0, 0,       0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 0,       0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,       0, 0, 0, 0, 0);
    add(1, 1, 0, 0, 0,       0, 1, 1, 1, 0);
    add(1, 0, 0, 0, 0,       0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0,       0, 0, 1, 1, 0);
    add(1, 1, 0, 0, 0,       0, 0, 1, 1, 0);
    add(0, 0, 1, 1, 4'b1011, 0, 0, 1, 1, 0);
    // valid gaps with in_bit toggling
    add(1, 1, 1, 0, 0,       0, 0, 1, 1, 0);
    add(0, 0, 1, 0, 0,       0, 0, 1, 1, 0);
    add(1, 0, 1, 0, 0,       0, 0, 1, 1, 0);
    add(0, 1, 1, 0, 0,       0, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0,       0, 0, 1, 1, 0);
    add(0, 1, 1, 0, 0,       0, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0,       0, 1, 2, 2, 0);
    // runtime load after 1,0,1
    add(1, 1, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 0, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 1, 1, 0, 0,       0, 0, 2, 2, 0);
    add(0, 0, 1, 1, 4'b0110, 0, 0, 2, 2, 0);
    add(1, 1, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 0, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 1, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 1, 1, 0, 0,       0, 0, 2, 2, 0);
    add(1, 0, 1, 0, 0,       0, 1, 3, 3, 1);
    add(1, 1, 1, 0, 0,       0, 0, 3, 3, 1);
    add(1, 1, 1, 0, 0,       0, 0, 3, 3, 1);
    // load with valid: completing bit discarded
    add(1, 0, 1, 1, 4'b0110, 0, 0, 3, 3, 1);
    add(1, 0, 1, 0, 0,       0, 0, 3, 3, 1);
    add(1, 1, 1, 0, 0,       0, 0, 3, 3, 1);
    add(1, 1, 1, 0, 0,       0, 0, 3, 3, 1);
    add(1, 0, 1, 0, 0,       0, 1, 4, 3, 1);
    // clear wins over simultaneous match
    add(1, 1, 1, 0, 0,       0, 0, 4, 3, 1);
    add(1, 1, 1, 0, 0,       0, 0, 4, 3, 1);
    add(1, 0, 1, 0, 0,       1, 1, 0, 0, 0);
    // one more match, then 1,0,1 ahead of the async reset
    add(1, 1, 1, 0, 0,       0, 0, 0, 0, 0);
    add(1, 1, 1, 0, 0,       0, 0, 0, 0, 0);
    add(1, 0, 1, 0, 0,       0, 1, 1, 1, 0);
    add(1, 1, 1, 0, 0,       0, 0, 1, 1, 0);
    add(1, 0, 1, 0, 0,       0, 0, 1, 1, 0);
    add(1, 1, 1, 0, 0,       0, 0, 1, 1, 0);

    reset = 1'b1; in_valid = 1'b0; in_bit = 1'b0; overlap = 1'b1;
    pat_load = 1'b0; pat_in = 4'b0000; count_clr = 1'b0;
    #12;
    chk("reset out",  {7'b0, out}, 8'h00);
    chk("reset cnt",  match_count, 8'h00);
    chk("reset sat",  {7'b0, count_sat}, 8'h00);
    chk("reset sat2", {7'b0, count_sat2}, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i], $sformatf("row%0d", i));
    end

    // async reset between edges, with a would-be-accepted bit on the inputs
    in_valid = 1'b1; in_bit = 1'b1; pat_load = 1'b0; count_clr = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    chk("async cnt",  match_count, 8'h00);
    chk("async cnt2", {6'b0, match_count2}, 8'h00);
    chk("async out",  {7'b0, out}, 8'h00);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "post1");
    step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "post2");
    step(mk(1, 0, 1, 0, 0, 0, 0, 0, 0, 0), "post3");
    step(mk(1, 1, 1, 0, 0, 0, 0, 0, 0, 0), "post4");
    step(mk(1, 1, 1, 0, 0, 0, 1, 1, 1, 0), "post5");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
